// File: rtl/result_trace_uart_tx_pkg.sv
// Shared types and constants for the result-trace UART transmitter.
// Holds the UART state encoding, the word/byte geometry and a byte-select helper.
package result_trace_uart_tx_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int BIT_IDX_W      = $clog2(BITS_PER_BYTE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Byte 0 is the most significant byte so the trace reads MSB first on the wire.
    function automatic logic [BITS_PER_BYTE-1:0] word_byte(
        input logic [WORD_W-1:0]     word,
        input logic [BYTE_IDX_W-1:0] idx
    );
        logic [BITS_PER_BYTE-1:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/result_trace_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering result words ahead of the UART.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
import result_trace_uart_tx_pkg::*;

module result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // so clearing it would add reset fan-out and block RAM inference for nothing.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_trace_uart_tx.sv
// Captures retiring memory-stage ALU results and streams them out as 8N1 UART bytes,
// four bytes per word, most significant byte first.
import result_trace_uart_tx_pkg::*;

module result_trace_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            ResultValid,
    input  logic [31:0]                     AluResult_Memory,
    output logic                            TxD,
    output logic                            Busy,
    output logic                            Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] FifoCount
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(CLKS_PER_BIT-1);
    localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(BITS_PER_BYTE-1);
    localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(BYTES_PER_WORD-1);

    uart_state_e            r_state;
    logic [TMR_W-1:0]       r_tmr;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BYTE_IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-1:0]      r_shift;
    logic                   r_txd;
    logic                   r_overflow;

    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [WORD_W-1:0]        w_fifo_rdata;
    logic [CNT_W-1:0]         w_fifo_count;
    logic                     w_pop;
    logic                     w_tmr_done;
    logic [BITS_PER_BYTE-1:0] w_cur_byte;

    assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_tmr_done = (r_tmr == TMR_LAST);
    assign w_cur_byte = word_byte(r_shift, r_byte_idx);

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_push  (ResultValid),
        .i_pop   (w_pop),
        .i_wdata (AluResult_Memory),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The timer restarts at every state boundary so each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmr <= '0;
                    if (w_pop) begin
                        r_shift    <= w_fifo_rdata;
                        r_byte_idx <= '0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tmr_done) begin
                        r_tmr     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tmr_done) begin
                        r_tmr <= '0;
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    if (w_tmr_done) begin
                        r_tmr <= '0;
                        if (r_byte_idx == BYTE_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
                            r_state    <= ST_START;
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
            endcase
        end
    end

    // TxD is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_txd <= 1'b1;
        end else begin
            case (r_state)
                ST_START: r_txd <= 1'b0;
                ST_DATA:  r_txd <= w_cur_byte[r_bit_idx];
                default:  r_txd <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else if (ResultValid && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign TxD       = r_txd;
    assign Overflow  = r_overflow;
    assign FifoCount = w_fifo_count;
    assign Busy      = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule
